mux2_rr_stream_arb: RTL
=======================

// Module: mux2_rr_stream_arb
// PURPOSE
//  Two-channel valid/ready stream arbiter that drives the select of the downstream 2:1 gate-level mux.
//  - Picks one of two input streams each cycle and exports the choice on sel (0 = in0, 1 = in1).
//  - Captures the selected beat in a single output register.
//  - Round-robin with a burst limit, so neither channel starves.
// PARAMETERS
//  WIDTH      8  data width of in0_data, in1_data and out_data
//  MAX_BURST  4  max consecutive beats from one channel while the other is waiting; >=1; 1 = strict alternation
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in0_valid  in   1      channel 0 beat available
//  in0_data   in   WIDTH  channel 0 data
//  in0_ready  out  1      channel 0 beat accepted this cycle (when in0_valid=1)
//  in1_valid  in   1      channel 1 beat available
//  in1_data   in   WIDTH  channel 1 data
//  in1_ready  out  1      channel 1 beat accepted this cycle (when in1_valid=1)
//  sel        out  1      current pick; drives s of the downstream 2:1 mux
//  out_valid  out  1      out_data holds a beat
//  out_data   out  WIDTH  registered selected data
//  out_src    out  1      channel that produced out_data
//  out_ready  in   1      consumer takes the beat
// BEHAVIOUR
//  State: cur (owner, 1b) and cnt (consecutive beats from cur, 0..MAX_BURST, saturating).
//  Reset values (async, immediate on rst=1): cur=0, cnt=0, out_valid=0, out_data=0, out_src=0.
//  load = ~out_valid | out_ready.
//  pick, combinational, evaluated every cycle:
//   - only in0_valid -> 0; only in1_valid -> 1; neither -> cur
//   - both valid: cur if cnt<MAX_BURST, else ~cur
//  Outputs and handshake:
//   - sel = pick
//   - in0_ready = load & (pick==0); in1_ready = load & (pick==1)
//   - ready may depend on valid; valid must never depend on ready
//   - accept = load & valid of the picked channel
//  On accept (rising clk):
//   - out_data <= picked data; out_src <= pick; out_valid <= 1
//   - pick==cur: cnt <= min(cnt+1, MAX_BURST)
//   - else: cur <= pick, cnt <= 1
//  On load without accept: out_valid <= 0; cur and cnt hold.
//  On ~load (out_valid=1 & out_ready=0):
//   - out_* hold, both readies 0, cur and cnt hold
//   - sel still tracks pick
//  Latency: 1 cycle from input accept to out_valid. Full throughput: 1 beat/cycle when out_ready=1.
//  Boundary conditions:
//   - both channels valid at reset release -> in0 granted first
//   - cnt saturates at MAX_BURST; it never wraps
//   - sole-valid channel keeps winning past MAX_BURST, with no idle bubble
//   - rst mid-transfer discards the held beat; no ready is asserted during rst
//   - simultaneous accept and drain in the same cycle -> new beat replaces old, out_valid stays 1
// CONFIGURATION
//  MUX2_ARB_STATS_EN
//   - defined: adds outputs beats0 and beats1 (out, 16b each)
//   - each counts accepted beats per channel
//   - reset to 0; wraps 16'hFFFF -> 0
//   - the ports are added after out_ready
//   - not defined: ports and counters are absent; all other behaviour is identical
// TESTING
//  1 Reset: hold rst=1 with in0/in1 valid -> out_valid=0, out_data=0, in0_ready=in1_ready=0, sel=0.
//  2 Contention, MAX_BURST=4, both always valid, out_ready=1 -> out_src 0,0,0,0,1,1,1,1,0...; sel matches.
//  3 Sole channel: only in1_valid for 10 cycles, out_ready=1 -> 10 beats, out_src=1, no gaps,
//    cnt held at 4, then in0 arrives while in1 stays valid -> next grant is in0.
//  4 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, readies 0,
//    cur/cnt unchanged; release -> the beat is taken and a new one loads in the same cycle.
//  5 Async reset mid-burst: assert rst between clock edges after 2 in0 beats -> out_valid=0 immediately;
//    after release with both valid, in0 is granted.
//  6 MUX2_ARB_STATS_EN: 7 beats on in0 and 5 on in1 -> beats0=7, beats1=5;
//    preload via 65536 in0 beats -> beats0 wraps to 0.

Source files
------------

// File: rtl/mux2_rr_stream_arb.sv
// Two-channel valid/ready round-robin arbiter with burst limit and one output register.
// Define MUX2_ARB_STATS_EN to add 16-bit per-channel accepted-beat counters (beats0/beats1).
module mux2_rr_stream_arb #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
`ifdef MUX2_ARB_STATS_EN
    ,
    output logic [15:0]      beats0,
    output logic [15:0]      beats1
`endif
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    logic          cur;
    logic          cur_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          pick;
    logic          pick_valid;
    logic          load;
    logic          accept;

    // Arbitration state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= 1'b0;
            cnt <= '0;
        end else begin
            cur <= cur_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Pick, handshake and select
    always_comb begin
        load = ~out_valid | out_ready;
        unique case ({in1_valid, in0_valid})
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = (cnt < CNT_MAX) ? cur : ~cur;
            default: pick = cur;
        endcase
        pick_valid = pick ? in1_valid : in0_valid;
        // Readies stay low while reset is held
        accept     = ~rst & load & pick_valid;
        in0_ready  = ~rst & load & ~pick;
        in1_ready  = ~rst & load & pick;
        sel        = pick;
    end

    // Owner and burst count; count saturates instead of wrapping
    always_comb begin
        cur_nxt = cur;
        cnt_nxt = cnt;
        if (accept) begin
            if (pick == cur) begin
                if (cnt != CNT_MAX)
                    cnt_nxt = cnt + 1'b1;
            end else begin
                cur_nxt = pick;
                cnt_nxt = CW'(1);
            end
        end
    end

    // Output register: a drain and a new load may happen on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
        end else if (load) begin
            out_valid <= accept;
            if (accept) begin
                out_data <= pick ? in1_data : in0_data;
                out_src  <= pick;
            end
        end
    end

`ifdef MUX2_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats0 <= '0;
            beats1 <= '0;
        end else if (accept) begin
            if (pick)
                beats1 <= beats1 + 16'd1;
            else
                beats0 <= beats0 + 16'd1;
        end
    end
`endif

endmodule
